// File: rtl/multicycle_control_unit_if.sv
// ---------------------------------------------------------------------------
// multicycle_control_unit_if
// Shared instruction/data memory port between the multicycle controller and
// the memory system. One request is outstanding at a time; the access
// completes in the cycle where mem_ready is high while mem_req is high.
//
// Signals:
//   mem_req    controller -> memory  request valid
//   mem_we     controller -> memory  1 = write, 0 = read
//   mem_size   controller -> memory  01 = halfword, 10 = word
//   mem_ready  memory -> controller  access completes this cycle
// Modports:
//   master  controller side
//   slave   memory side
// ---------------------------------------------------------------------------
interface multicycle_control_unit_if;
  logic       mem_req;
  logic       mem_we;
  logic [1:0] mem_size;
  logic       mem_ready;

  modport master (output mem_req, output mem_we, output mem_size, input mem_ready);
  modport slave  (input mem_req, input mem_we, input mem_size, output mem_ready);
endinterface

// File: rtl/multicycle_control_unit.sv
// ---------------------------------------------------------------------------
// multicycle_control_unit
// FSM controller for a multicycle RV32I-subset datapath. Sequences fetch,
// decode, execute, memory and writeback, drives every datapath enable and
// mux select, shares one memory port for instruction and data accesses,
// traps on unsupported encodings or memory timeouts and counts retired
// instructions.
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   mem            memory handshake (req/we/size out, ready in)
//   instr          instruction register contents
//   alu_zero       ALU zero flag (used by branches)
//   ir_write, pc_write, pc_src, target_write      register load controls
//   alu_src_a, alu_src_b, alu_control             ALU operand/op selects
//   reg_write, mem_to_reg                         register file writeback
//   illegal_instr, mem_timeout                    sticky trap causes
//   instr_retired                                 wrapping retire counter
// ---------------------------------------------------------------------------
module multicycle_control_unit #(
  parameter int ALU_CTRL_W  = 4,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  multicycle_control_unit_if.master mem,
  input  logic [31:0]               instr,
  input  logic                      alu_zero,
  output logic                      ir_write,
  output logic                      pc_write,
  output logic                      pc_src,
  output logic                      target_write,
  output logic                      alu_src_a,
  output logic [1:0]                alu_src_b,
  output logic [ALU_CTRL_W-1:0]     alu_control,
  output logic                      reg_write,
  output logic                      mem_to_reg,
  output logic                      illegal_instr,
  output logic                      mem_timeout,
  output logic [CNT_W-1:0]          instr_retired
);

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SLL = 4'b0011;
  localparam logic [3:0] ALU_XOR = 4'b0100;
  localparam logic [3:0] ALU_SRL = 4'b0101;
  localparam logic [3:0] ALU_SUB = 4'b0110;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  // Wait counter only has to reach MEM_TIMEOUT-1; the timeout fires in the
  // cycle whose low mem_ready would bring the count to MEM_TIMEOUT.
  localparam int                WAIT_W    = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = (MEM_TIMEOUT > 0) ? WAIT_W'(MEM_TIMEOUT - 1) : '0;

  typedef enum logic [3:0] {
    RST, FETCH, DECODE, EXEC_R, EXEC_I, MEM_ADDR,
    MEM_RD, MEM_WR, WB_ALU, WB_MEM, BRANCH, TRAP
  } state_t;

  state_t              state, state_next;
  logic [WAIT_W-1:0]   wait_cnt;
  logic [CNT_W-1:0]    retired_q;
  logic                illegal_q, timeout_q;
  logic                illegal_hit, timeout_hit, retire, waiting, wait_expired;
  logic [3:0]          alu_op, dec_op;
  logic                r_legal, i_legal;
  logic [1:0]          dec_size;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];

  // Register index fields go straight to the datapath; the controller never looks at them.
  logic unused_instr_bits;
  assign unused_instr_bits = ^{instr[24:15], instr[11:7]};

  // funct3 -> ALU op shared by R and I forms. SUB exists only as R-type with
  // funct7[5]; shifts need funct7 = 0 in both forms; other I-types ignore
  // funct7 because those bits belong to the immediate.
  always_comb begin
    dec_op  = ALU_ADD;
    r_legal = 1'b0;
    i_legal = 1'b0;
    case (funct3)
      3'b000: begin
        dec_op  = ALU_ADD;
        r_legal = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
        i_legal = 1'b1;
      end
      3'b111: begin dec_op = ALU_AND; r_legal = (funct7 == 7'b0); i_legal = 1'b1; end
      3'b110: begin dec_op = ALU_OR;  r_legal = (funct7 == 7'b0); i_legal = 1'b1; end
      3'b100: begin dec_op = ALU_XOR; r_legal = (funct7 == 7'b0); i_legal = 1'b1; end
      3'b001: begin dec_op = ALU_SLL; r_legal = (funct7 == 7'b0); i_legal = (funct7 == 7'b0); end
      3'b101: begin dec_op = ALU_SRL; r_legal = (funct7 == 7'b0); i_legal = (funct7 == 7'b0); end
      default: ;
    endcase

    dec_size = 2'b00;
    if (funct3 == 3'b001)      dec_size = 2'b01;
    else if (funct3 == 3'b010) dec_size = 2'b10;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RST;
      wait_cnt  <= '0;
      retired_q <= '0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state <= state_next;
      if (state_next != state)
        wait_cnt <= '0;
      else if (waiting && !mem.mem_ready)
        wait_cnt <= wait_cnt + 1'b1;
      if (illegal_hit) illegal_q <= 1'b1;
      if (timeout_hit) timeout_q <= 1'b1;
      if (retire)      retired_q <= retired_q + 1'b1;
    end
  end

  always_comb begin
    state_next   = state;
    mem.mem_req  = 1'b0;
    mem.mem_we   = 1'b0;
    mem.mem_size = 2'b00;
    ir_write     = 1'b0;
    pc_write     = 1'b0;
    pc_src       = 1'b0;
    target_write = 1'b0;
    alu_src_a    = 1'b0;
    alu_src_b    = 2'b00;
    alu_op       = ALU_AND;
    reg_write    = 1'b0;
    mem_to_reg   = 1'b0;
    illegal_hit  = 1'b0;
    timeout_hit  = 1'b0;
    waiting      = (state == FETCH) || (state == MEM_RD) || (state == MEM_WR);
    // A ready in the threshold cycle wins, so mem_ready gates expiry.
    wait_expired = (MEM_TIMEOUT != 0) && !mem.mem_ready && (wait_cnt == WAIT_LAST);

    case (state)
      RST: state_next = FETCH;
      FETCH: begin
        mem.mem_req  = 1'b1;
        mem.mem_size = 2'b10;
        alu_src_b    = 2'b10;
        alu_op       = ALU_ADD;
        if (mem.mem_ready) begin
          ir_write   = 1'b1;
          pc_write   = 1'b1;
          state_next = DECODE;
        end else if (wait_expired) begin
          timeout_hit = 1'b1;
          state_next  = TRAP;
        end
      end
      DECODE: begin
        alu_src_b    = 2'b01;
        alu_op       = ALU_ADD;
        target_write = 1'b1;
        case (opcode)
          OP_R:               state_next = EXEC_R;
          OP_I:               state_next = EXEC_I;
          OP_LOAD, OP_STORE:  state_next = MEM_ADDR;
          OP_BRANCH:          state_next = BRANCH;
          default: begin illegal_hit = 1'b1; state_next = TRAP; end
        endcase
      end
      EXEC_R: begin
        alu_src_a   = 1'b1;
        alu_op      = (funct3 == 3'b000 && funct7[5]) ? ALU_SUB : dec_op;
        illegal_hit = !r_legal;
        state_next  = r_legal ? WB_ALU : TRAP;
      end
      EXEC_I: begin
        alu_src_a   = 1'b1;
        alu_src_b   = 2'b01;
        alu_op      = dec_op;
        illegal_hit = !i_legal;
        state_next  = i_legal ? WB_ALU : TRAP;
      end
      WB_ALU: begin
        reg_write  = 1'b1;
        state_next = FETCH;
      end
      MEM_ADDR: begin
        alu_src_a    = 1'b1;
        alu_src_b    = 2'b01;
        alu_op       = ALU_ADD;
        mem.mem_size = dec_size;
        if (dec_size == 2'b00) begin
          illegal_hit = 1'b1;
          state_next  = TRAP;
        end else begin
          state_next = (opcode == OP_STORE) ? MEM_WR : MEM_RD;
        end
      end
      MEM_RD: begin
        mem.mem_req  = 1'b1;
        mem.mem_size = dec_size;
        if (mem.mem_ready)     state_next = WB_MEM;
        else if (wait_expired) begin timeout_hit = 1'b1; state_next = TRAP; end
      end
      WB_MEM: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        state_next = FETCH;
      end
      MEM_WR: begin
        mem.mem_req  = 1'b1;
        mem.mem_we   = 1'b1;
        mem.mem_size = dec_size;
        if (mem.mem_ready)     state_next = FETCH;
        else if (wait_expired) begin timeout_hit = 1'b1; state_next = TRAP; end
      end
      BRANCH: begin
        alu_src_a  = 1'b1;
        alu_op     = ALU_SUB;
        pc_src     = 1'b1;
        state_next = FETCH;
        case (funct3)
          3'b000:  pc_write = alu_zero;
          3'b001:  pc_write = !alu_zero;
          default: begin illegal_hit = 1'b1; state_next = TRAP; end
        endcase
      end
      TRAP: state_next = TRAP;
      default: state_next = RST;
    endcase
  end

  assign retire = (state_next == FETCH) &&
                  ((state == WB_ALU) || (state == WB_MEM) || (state == MEM_WR) || (state == BRANCH));

  assign alu_control   = ALU_CTRL_W'(alu_op);
  assign illegal_instr = illegal_q;
  assign mem_timeout   = timeout_q;
  assign instr_retired = retired_q;

endmodule
